// File: rtl/layer_sequencer_pkg.sv
// rtl/layer_sequencer_pkg.sv - shared types and constants for the three-layer conv sequencer
// Contents: layer_type_t (LAYER1/2/3), default per-layer tile counts,
//           seq_state_t sequencer states, next_layer() helper.
package layer_sequencer_pkg;

    typedef enum logic [1:0] {
        LAYER1 = 2'd0,
        LAYER2 = 2'd1,
        LAYER3 = 2'd2
    } layer_type_t;

    localparam int LAYER1_COUNT = 16;
    localparam int LAYER2_COUNT = 4;
    localparam int LAYER3_COUNT = 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_FREE = 3'd3,
        ST_NEXT = 3'd4,
        ST_DONE = 3'd5
    } seq_state_t;

    // LAYER3 is terminal; the sequencer never advances past it.
    function automatic layer_type_t next_layer(input layer_type_t cur);
        layer_type_t nxt;
        case (cur)
            LAYER1:  nxt = LAYER2;
            LAYER2:  nxt = LAYER3;
            default: nxt = LAYER3;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/layer_sequencer_counter.sv
// rtl/layer_sequencer_counter.sv - per-layer tile counter with target compare
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   i_clear        zero the counter (takes priority over i_inc)
//   i_inc          add one completed tile
//   i_layer        current layer, selects the tile target
//   o_count        tiles completed in the current layer
//   o_last_tile    o_count equals the target of i_layer
module layer_tile_counter
    import layer_sequencer_pkg::*;
#(
    parameter int COUNT_W  = 5,
    parameter int L1_TILES = LAYER1_COUNT,
    parameter int L2_TILES = LAYER2_COUNT,
    parameter int L3_TILES = LAYER3_COUNT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clear,
    input  logic               i_inc,
    input  logic [1:0]         i_layer,
    output logic [COUNT_W-1:0] o_count,
    output logic               o_last_tile
);

    localparam logic [COUNT_W-1:0] C_L1 = COUNT_W'(L1_TILES);
    localparam logic [COUNT_W-1:0] C_L2 = COUNT_W'(L2_TILES);
    localparam logic [COUNT_W-1:0] C_L3 = COUNT_W'(L3_TILES);

    logic [COUNT_W-1:0] r_count;
    logic [COUNT_W-1:0] w_target;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + COUNT_W'(1);
        end
    end

    always_comb begin
        w_target = C_L3;
        case (layer_type_t'(i_layer))
            LAYER1:  w_target = C_L1;
            LAYER2:  w_target = C_L2;
            default: w_target = C_L3;
        endcase
    end

    // Full-width compare on the registered count; targets never reach 2^COUNT_W.
    assign o_count     = r_count;
    assign o_last_tile = (r_count == w_target);

endmodule

// File: rtl/layer_sequencer.sv
// rtl/layer_sequencer.sv - steps the PE array through LAYER1..LAYER3, one PE start per ifmap tile
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start               host pulse, begins a full three-layer run
//   buf_ready           level, ifmap buffer holds the next tile
//   complete            PE array pulse, current tile finished
//   pe_start            pulse, PE array may consume the buffered tile
//   free_ifmap_buffer   pulse, loader may overwrite the ifmap buffer
//   layer_type          current layer (0=LAYER1, 1=LAYER2, 2=LAYER3)
//   tile_count          tiles completed in the current layer
//   busy                high from accepted start until done
//   done                pulse, LAYER3 finished
//   protocol_err        sticky, complete seen outside RUN
module layer_sequencer
    import layer_sequencer_pkg::*;
#(
    parameter int COUNT_W  = 5,
    parameter int L1_TILES = LAYER1_COUNT,
    parameter int L2_TILES = LAYER2_COUNT,
    parameter int L3_TILES = LAYER3_COUNT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               buf_ready,
    input  logic               complete,
    output logic               pe_start,
    output logic               free_ifmap_buffer,
    output logic [1:0]         layer_type,
    output logic [COUNT_W-1:0] tile_count,
    output logic               busy,
    output logic               done,
    output logic               protocol_err
);

    seq_state_t  r_state;
    seq_state_t  w_state_nxt;
    layer_type_t r_layer;
    layer_type_t w_layer_nxt;

    logic r_pe_start;
    logic r_free;
    logic r_busy;
    logic r_done;
    logic r_err;

    logic w_pe_start_nxt;
    logic w_free_nxt;
    logic w_busy_nxt;
    logic w_done_nxt;
    logic w_err_nxt;
    logic w_cnt_clear;
    logic w_cnt_inc;
    logic w_last_tile;

    layer_tile_counter #(
        .COUNT_W  (COUNT_W),
        .L1_TILES (L1_TILES),
        .L2_TILES (L2_TILES),
        .L3_TILES (L3_TILES)
    ) u_tile_counter (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (w_cnt_clear),
        .i_inc       (w_cnt_inc),
        .i_layer     (r_layer),
        .o_count     (tile_count),
        .o_last_tile (w_last_tile)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_layer    <= LAYER1;
            r_pe_start <= 1'b0;
            r_free     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_layer    <= w_layer_nxt;
            r_pe_start <= w_pe_start_nxt;
            r_free     <= w_free_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
        end
    end

    // Pulse outputs are computed one state early so they are high during
    // the state they belong to (pe_start in the first RUN cycle, free in
    // FREE, done in DONE) while still coming straight from flops.
    always_comb begin
        w_state_nxt    = r_state;
        w_layer_nxt    = r_layer;
        w_pe_start_nxt = 1'b0;
        w_free_nxt     = 1'b0;
        w_done_nxt     = 1'b0;
        w_busy_nxt     = r_busy;
        w_err_nxt      = r_err;
        w_cnt_clear    = 1'b0;
        w_cnt_inc      = 1'b0;

        // Stray completions are flagged; an accepted start below overrides.
        if (complete && (r_state != ST_RUN)) begin
            w_err_nxt = 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_LOAD;
                    w_layer_nxt = LAYER1;
                    w_cnt_clear = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_err_nxt   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (buf_ready) begin
                    w_state_nxt    = ST_RUN;
                    w_pe_start_nxt = 1'b1;
                end
            end
            ST_RUN: begin
                if (complete) begin
                    w_state_nxt = ST_FREE;
                    w_cnt_inc   = 1'b1;
                    w_free_nxt  = 1'b1;
                end
            end
            ST_FREE: begin
                // tile_count already includes the tile that just finished.
                w_state_nxt = w_last_tile ? ST_NEXT : ST_LOAD;
            end
            ST_NEXT: begin
                w_cnt_clear = 1'b1;
                if (r_layer == LAYER3) begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = ST_LOAD;
                    w_layer_nxt = next_layer(r_layer);
                end
            end
            ST_DONE: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign pe_start          = r_pe_start;
    assign free_ifmap_buffer = r_free;
    assign layer_type        = r_layer;
    assign busy              = r_busy;
    assign done              = r_done;
    assign protocol_err      = r_err;

endmodule

// File: tb/tb_layer_sequencer.sv
// tb/tb_layer_sequencer.sv - self-checking bench for layer_sequencer
module tb_layer_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       buf_ready;
    logic       complete;
    logic       pe_start;
    logic       free_ifmap_buffer;
    logic [1:0] layer_type;
    logic [4:0] tile_count;
    logic       busy;
    logic       done;
    logic       protocol_err;

    always #5 clk = ~clk;

    layer_sequencer #(
        .COUNT_W  (5),
        .L1_TILES (16),
        .L2_TILES (4),
        .L3_TILES (1)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .buf_ready         (buf_ready),
        .complete          (complete),
        .pe_start          (pe_start),
        .free_ifmap_buffer (free_ifmap_buffer),
        .layer_type        (layer_type),
        .tile_count        (tile_count),
        .busy              (busy),
        .done              (done),
        .protocol_err      (protocol_err)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: edge-indexed schedule. Each completed tile schedules
    // the edge at which the next load may begin, or a layer change, or the
    // end of the run, as fixed offsets from the completion edge.
    int tgt [3] = '{16, 4, 1};
    int edge_n = 0;
    int m_load_from = -1, m_pe_edge = -1, m_adv_edge = -1, m_fin_edge = -1;
    int m_layer = 0, m_cnt = 0;
    bit m_run = 0, m_busy = 0, m_err = 0, m_pe = 0, m_free = 0, m_done = 0;

    task automatic model_edge();
        int k;
        bit busy_before;
        bit legal;
        edge_n++;
        k = edge_n;
        if (!rst_n) begin
            m_busy = 0; m_err = 0; m_pe = 0; m_free = 0; m_done = 0;
            m_layer = 0; m_cnt = 0; m_run = 0;
            m_load_from = -1; m_pe_edge = -1; m_adv_edge = -1; m_fin_edge = -1;
        end else begin
            busy_before = m_busy;
            legal = m_run && (k > m_pe_edge);
            m_pe = 0; m_free = 0; m_done = 0;
            if (complete && !legal) m_err = 1;
            if (k == m_adv_edge) begin
                m_adv_edge = -1;
                m_cnt = 0;
                if (m_layer == 2) begin
                    m_done = 1;
                    m_fin_edge = k + 1;
                end else begin
                    m_layer++;
                    m_load_from = k + 1;
                end
            end
            if (k == m_fin_edge) begin
                m_busy = 0;
                m_fin_edge = -1;
            end
            if (!busy_before && start) begin
                m_busy = 1; m_err = 0; m_layer = 0; m_cnt = 0;
                m_load_from = k + 1;
            end
            if (m_load_from >= 0 && k >= m_load_from && buf_ready) begin
                m_pe = 1; m_run = 1; m_pe_edge = k; m_load_from = -1;
            end else if (legal && complete) begin
                m_cnt++;
                m_free = 1;
                m_run = 0;
                if (m_cnt == tgt[m_layer]) m_adv_edge = k + 2;
                else m_load_from = k + 2;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_edge();
    end

    initial forever begin
        @(negedge clk);
        if (edge_n > 0) begin
            chk("pe_start", pe_start, m_pe);
            chk("free_ifmap_buffer", free_ifmap_buffer, m_free);
            chk("layer_type", layer_type, m_layer);
            chk("tile_count", tile_count, m_cnt);
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("protocol_err", protocol_err, m_err);
        end
    end

    // Stimulus helpers
    int cyc = 0;
    int resp_delay = -1, rcnt = -1;
    int hold = 0, rise_cyc = -1;
    bit buf_mode = 0;
    int inj_pe = 0;
    int n_pe = 0, n_free = 0, n_done = 0, l2_at = -1, l3_at = -1;
    logic [1:0] prev_layer = 2'd0;

    task automatic step();
        @(negedge clk);
        cyc++;
        start = 1'b0;
        complete = 1'b0;
        if (pe_start) n_pe++;
        if (free_ifmap_buffer) n_free++;
        if (done) n_done++;
        if (layer_type != prev_layer) begin
            if (layer_type == 2'd1) l2_at = n_free;
            else if (layer_type == 2'd2) l3_at = n_free;
            prev_layer = layer_type;
        end
        if (resp_delay >= 0) begin
            if (pe_start) rcnt = resp_delay;
            else if (rcnt > 0) rcnt--;
            if (rcnt == 0) begin
                complete = 1'b1;
                rcnt = -1;
            end
        end
        if (buf_mode) begin
            if (pe_start && rise_cyc >= 0) begin
                chk("pe_after_buf_rise", cyc - rise_cyc, 1);
                rise_cyc = -1;
            end
            if (hold > 0) begin
                hold--;
                if (hold == 0) begin
                    buf_ready = 1'b1;
                    rise_cyc = cyc;
                end
            end
            if (free_ifmap_buffer) begin
                buf_ready = 1'b0;
                hold = 11;
            end
        end
        if (inj_pe > 0 && pe_start && n_pe == inj_pe) start = 1'b1;
    endtask

    task automatic clear_counts();
        n_pe = 0; n_free = 0; n_done = 0; l2_at = -1; l3_at = -1;
        prev_layer = layer_type;
    endtask

    task automatic run_to_done(input int budget);
        bit got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            step();
            if (done) got = 1;
        end
        chk("done_within_budget", got, 1);
        if (got) begin
            step();
            chk("busy_after_done", busy, 0);
            chk("layer_after_done", layer_type, 2);
            chk("count_after_done", tile_count, 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit found;
        int free_snap;
        rst_n = 1'b0; start = 1'b0; buf_ready = 1'b0; complete = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        chk("reset_busy", busy, 0);
        chk("reset_layer", layer_type, 0);
        chk("reset_count", tile_count, 0);
        chk("reset_err", protocol_err, 0);
        chk("reset_pe", pe_start, 0);

        // Full run: buf_ready tied high, complete 3 cycles after each pe_start
        buf_ready = 1'b1; resp_delay = 3;
        clear_counts();
        start = 1'b1;
        run_to_done(400);
        chk("run1_pe_pulses", n_pe, 21);
        chk("run1_free_pulses", n_free, 21);
        chk("run1_done_pulses", n_done, 1);
        chk("run1_layer2_at_free", l2_at, 16);
        chk("run1_layer3_at_free", l3_at, 20);

        // complete coincident with the pe_start cycle
        resp_delay = 0;
        clear_counts();
        start = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (free_ifmap_buffer) found = 1;
        end
        chk("coincident_first_free_seen", found, 1);
        chk("coincident_first_count", tile_count, 1);
        run_to_done(400);
        chk("coincident_pe_pulses", n_pe, 21);
        chk("coincident_free_pulses", n_free, 21);

        // start pulsed during RUN of LAYER1 tile 5 is ignored
        resp_delay = 3; inj_pe = 5;
        clear_counts();
        start = 1'b1;
        run_to_done(400);
        inj_pe = 0;
        chk("inject_pe_pulses", n_pe, 21);
        chk("inject_done_pulses", n_done, 1);

        // buf_ready held low for 10 cycles in every LOAD
        buf_mode = 1; buf_ready = 1'b0; hold = 11; rise_cyc = -1;
        clear_counts();
        start = 1'b1;
        run_to_done(1000);
        buf_mode = 0; hold = 0; buf_ready = 1'b1;
        chk("holdoff_pe_pulses", n_pe, 21);
        chk("holdoff_free_pulses", n_free, 21);

        // complete while waiting in LOAD
        resp_delay = -1; rcnt = -1; buf_ready = 1'b0;
        start = 1'b1;
        step();
        step();
        complete = 1'b1;
        step();
        chk("load_complete_err", protocol_err, 1);
        chk("load_complete_count", tile_count, 0);
        buf_ready = 1'b1; resp_delay = 3;
        run_to_done(400);
        chk("err_sticky_after_done", protocol_err, 1);

        // start and complete together in IDLE: clear wins
        resp_delay = -1; rcnt = -1; buf_ready = 1'b0;
        start = 1'b1; complete = 1'b1;
        step();
        chk("start_clears_err", protocol_err, 0);
        chk("start_sets_busy", busy, 1);
        buf_ready = 1'b1; resp_delay = 3;
        run_to_done(400);

        // reset in the middle of LAYER2
        clear_counts();
        start = 1'b1;
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            step();
            if (layer_type == 2'd1 && tile_count == 5'd2) found = 1;
        end
        chk("mid_l2_reached", found, 1);
        resp_delay = -1; rcnt = -1;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_busy", busy, 0);
        chk("midrst_layer", layer_type, 0);
        chk("midrst_count", tile_count, 0);
        chk("midrst_pe", pe_start, 0);
        chk("midrst_free", free_ifmap_buffer, 0);
        chk("midrst_done", done, 0);
        chk("midrst_err", protocol_err, 0);
        free_snap = n_free;
        repeat (5) step();
        chk("midrst_stays_idle", busy, 0);
        chk("midrst_no_free", n_free - free_snap, 0);
        chk("midrst_no_done", n_done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
Top-level sequencer for the three-layer conv pipeline. It steps the PE array through LAYER1, LAYER2 and LAYER3 and issues one PE start per ifmap tile. It counts PE completion pulses against a per-layer tile target and releases the ifmap buffer after every tile. It sits between the host start/done handshake, the ifmap buffer loader (buf_ready / free_ifmap_buffer) and the PE array (pe_start / complete).

Parameters:
COUNT_W, 5, width of tile counter; must hold max(L*_TILES)
L1_TILES, 16, ifmap tiles (PE completes) per LAYER1 pass
L2_TILES, 4, tiles per LAYER2 pass
L3_TILES, 1, tiles per LAYER3 pass

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock; reset is synchronous and active-low
start  in  1  host pulse: begin full 3-layer run
buf_ready  in  1  level: ifmap buffer holds the next tile
complete  in  1  PE array pulse: current tile finished
pe_start  out  1  one-cycle pulse: PE array may consume the buffered tile
free_ifmap_buffer  out  1  one-cycle pulse: loader may overwrite the ifmap buffer
layer_type  out  LAYER_TYPE  current layer (LAYER1/LAYER2/LAYER3)
tile_count  out  COUNT_W  tiles completed in the current layer
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse: LAYER3 finished
protocol_err  out  1  sticky: complete seen outside RUN

Behaviour:
- Reset (rst_n low at posedge): state=IDLE; all outputs 0; layer_type=LAYER1; tile_count=0. Reset mid-run aborts immediately, with no done and no free pulse.
- All outputs are registered.
- FSM states: IDLE, LOAD, RUN, FREE, NEXT, DONE.
- IDLE:
  - start=1 -> LOAD next cycle.
  - Same edge: layer_type<=LAYER1, tile_count<=0, busy<=1, protocol_err<=0.
- LOAD:
  - Wait for buf_ready=1.
  - On that edge -> RUN, and pe_start=1 for exactly the first RUN cycle.
- RUN:
  - Wait for complete=1.
  - On that edge: tile_count<=tile_count+1 -> FREE.
  - complete is pulse-qualified; a complete in the same cycle pe_start is high is legal and counts.
- FREE:
  - free_ifmap_buffer=1 for this single cycle.
  - If tile_count==target(layer_type) -> NEXT, else -> LOAD.
  - target: LAYER1->L1_TILES, LAYER2->L2_TILES, LAYER3->L3_TILES.
  - Comparison is on the already-incremented value, full COUNT_W width, no wrap (parameters guarantee target < 2^COUNT_W).
- NEXT:
  - tile_count<=0.
  - layer_type==LAYER3 -> DONE; otherwise layer_type advances by one -> LOAD.
- DONE:
  - done=1 for one cycle; busy<=0 -> IDLE.
  - layer_type and tile_count hold final values (LAYER3, 0) until the next start.
- Latency:
  - buf_ready to pe_start: 1 cycle.
  - complete to free_ifmap_buffer: 1 cycle.
  - free to next pe_start: at least 2 cycles (LOAD entry + buf_ready).
- Boundary conditions:
  - start while busy: ignored, no effect.
  - complete in IDLE/LOAD/FREE/NEXT/DONE: ignored for counting; sets protocol_err (sticky until next accepted start).
  - complete and start in the same IDLE cycle: start accepted; protocol_err ends 0, because clear has priority over set.
  - buf_ready held high continuously: each LOAD still costs exactly one cycle.
  - Per full run: exactly L1_TILES+L2_TILES+L3_TILES (21) pe_start pulses and 21 free_ifmap_buffer pulses.

Decomposition:
- Shared package:
  - LAYER_TYPE enum (LAYER1, LAYER2, LAYER3; 2 bits).
  - Default tile constants LAYER1_COUNT=16, LAYER2_COUNT=4, LAYER3_COUNT=1.
  - Sequencer state enum.
- One natural sub-module: layer_tile_counter. It holds a COUNT_W counter with clear/inc, a target mux by LAYER_TYPE, and a last_tile compare output.
- The FSM stays in layer_sequencer.

Test Plan:
- Reset then start, buf_ready tied 1, complete pulsed 3 cycles after each pe_start -> 21 pe_start, 21 free pulses; layer_type 1->2->3 after 16 and 20 frees; done once; busy low after done.
- Mid-LAYER2 (tile_count=2) assert rst_n=0 one cycle -> next cycle all outputs 0, layer_type=LAYER1; no done/free pulse.
- Complete pulsed while in LOAD (buf_ready=0) -> tile_count unchanged, protocol_err=1 and stays 1 until the next start accepted in IDLE.
- Start pulsed during RUN of LAYER1 tile 5 -> ignored; run completes normally with 21 tiles total.
- buf_ready held low 10 cycles in each LOAD -> pe_start exactly 1 cycle after buf_ready rises; no pe_start while buf_ready=0.
- complete coincident with pe_start cycle -> counted; free_ifmap_buffer next cycle; tile_count increments by 1.
